reset_shutdown_sequencer: RTL and testbench
===========================================

Name: reset_shutdown_sequencer

Overview:
- Controls the synthesizer's staged subsystem resets through a full cycle: a staged power-up release, then on request an orderly shutdown and restart.
- On a software restart request, it first asks downstream audio to mute and waits for acknowledge or timeout.
- It then asserts the resets in reverse order (stage 2 first), holds, and releases in forward order (stage 0 first).
- It sits between the control/register block and the synthesizer voice, engine and output subsystems.

Parameters:
CNT_W, 22, width of internal wait counter; must hold max(GAP,HOLD,TIMEOUT)-1
GAP, 22'h100000, cycles between successive stage changes (>=1)
HOLD, 22'h100000, cycles all stages stay in reset during a restart (>=1)
TIMEOUT, 22'h3FFFFF, max cycles waiting for mute_ack (>=1)

Ports:
iCLK  in  1  system clock
reset_reg_N  in  1  asynchronous active-low reset
soft_req  in  1  restart request, level; rising edge is the trigger
mute_ack  in  1  downstream confirms audio muted
oRST_0  out  1  stage-0 reset, active-low (1 = running)
oRST_1  out  1  stage-1 reset, active-low
oRST_2  out  1  stage-2 reset, active-low
oMUTE_REQ  out  1  request downstream mute
oBUSY  out  1  sequencer not in RUN
oDONE  out  1  one-cycle pulse when all stages have been released
oTMO  out  1  sticky: last shutdown proceeded on timeout

Behaviour:
- Interface: reset reset_reg_N, asynchronous, active-low; clock iCLK. All outputs registered.
- Reset values:
  - oRST_0/1/2 = 0, oMUTE_REQ = 0, oBUSY = 1, oDONE = 0, oTMO = 0.
  - Internal state = PU0, cnt = 0, req_d (previous soft_req sample) = 0.
- Edge numbering: edge 1 is the first iCLK rising edge with reset_reg_N high.
- Wait states:
  - cnt clears on every state entry and increments each cycle.
  - A wait of N cycles exits on the edge where cnt == N-1, so the state occupies exactly N cycles.
  - Output changes take effect on that exit edge.
- States and transitions:
  - PU0 (GAP) -> PU1: oRST_0 <= 1.
  - PU1 (GAP) -> PU2: oRST_1 <= 1.
  - PU2 (GAP) -> RUN: oRST_2 <= 1, oMUTE_REQ <= 0, oBUSY <= 0, oDONE <= 1 for one cycle.
  - RUN: if soft_req == 1 and req_d == 0 -> MUTE: oMUTE_REQ <= 1, oBUSY <= 1, oTMO <= 0.
  - MUTE: if mute_ack == 1 -> DN1 with oRST_2 <= 0.
    - Else if cnt == TIMEOUT-1 -> DN1 with oRST_2 <= 0 and oTMO <= 1.
    - mute_ack has priority when both conditions hold on the same edge.
  - DN1 (GAP) -> DN0: oRST_1 <= 0.
  - DN0 (GAP) -> HOLD: oRST_0 <= 0.
  - HOLD (HOLD) -> PU1: oRST_0 <= 1; the sequence then continues through PU1 and PU2 as above.
- Power-up timing: oRST_0 rises after edge GAP, oRST_1 after edge 2*GAP, oRST_2 after edge 3*GAP.
- req_d samples soft_req every cycle in all states. Effects:
  - Edges occurring outside RUN are dropped, not queued.
  - A level held high through reset or busy never triggers.
- oMUTE_REQ stays high from MUTE entry until the exit of PU2. mute_ack is ignored outside MUTE.
- Stage ordering invariant: oRST_2 <= oRST_1 <= oRST_0 at all times. Shutdown order is 2,1,0; release order is 0,1,2.
- reset_reg_N low at any time:
  - Immediately returns all outputs and state to reset values, including from mid-shutdown.
  - The full power-up sequence reruns.
- oDONE is high only in the cycle after PU2 exit; it is never high while oBUSY == 1.

Test Plan:
Params GAP=4, HOLD=3, TIMEOUT=8; S = edge at which the request edge is detected.
- Power-up: release reset, soft_req=0 -> oRST_0 rises after edge 4, oRST_1 after 8, oRST_2 after 12; oBUSY falls and oDONE pulses for one cycle after edge 12.
- Restart with mute_ack tied 1:
  - oMUTE_REQ=1 after S.
  - Resets fall: oRST_2 after S+1, oRST_1 after S+5, oRST_0 after S+9.
  - Resets rise: oRST_0 after S+12, oRST_1 after S+16, oRST_2 after S+20.
  - oMUTE_REQ=0 and oDONE pulse after S+20; oTMO stays 0.
- Restart with mute_ack tied 0 -> oRST_2 falls after S+8 with oTMO=1. A second request with ack=1 clears oTMO at its S.
- soft_req held high through reset and power-up -> no restart. Pulse soft_req during shutdown -> ignored, no second cycle.
- Assert reset_reg_N low during DN0 -> all outputs 0 and oBUSY=1 immediately; the power-up sequence repeats as in test 1.
- Continuous assertion check over all tests: oRST_2<=oRST_1<=oRST_0, and oDONE never high while oBUSY=1.

Source files
------------

// File: rtl/reset_shutdown_sequencer.sv
// reset_shutdown_sequencer: staged power-up release, muted orderly shutdown and restart of subsystem resets
module reset_shutdown_sequencer #(
    parameter int CNT_W   = 22,
    parameter int GAP     = 22'h100000,
    parameter int HOLD    = 22'h100000,
    parameter int TIMEOUT = 22'h3FFFFF
) (
    input  logic iCLK,
    input  logic reset_reg_N,
    input  logic soft_req,
    input  logic mute_ack,
    output logic oRST_0,
    output logic oRST_1,
    output logic oRST_2,
    output logic oMUTE_REQ,
    output logic oBUSY,
    output logic oDONE,
    output logic oTMO
);
    localparam logic [CNT_W-1:0] GAP_M  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_M = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] TMO_M  = CNT_W'(TIMEOUT - 1);
    typedef enum logic [2:0] {ST_PU0, ST_PU1, ST_PU2, ST_RUN, ST_MUTE, ST_DN1, ST_DN0, ST_HOLD} state_t;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_q;
    // Sequencer: each wait state exits on the edge where cnt_q reaches its length minus one
    always_ff @(posedge iCLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q   <= ST_PU0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            oRST_0    <= 1'b0;
            oRST_1    <= 1'b0;
            oRST_2    <= 1'b0;
            oMUTE_REQ <= 1'b0;
            oBUSY     <= 1'b1;
            oDONE     <= 1'b0;
            oTMO      <= 1'b0;
        end else begin
            req_q <= soft_req;
            oDONE <= 1'b0;
            cnt_q <= cnt_q + 1'b1;
            case (state_q)
                ST_PU0: if (cnt_q == GAP_M) begin
                    state_q <= ST_PU1;
                    cnt_q   <= '0;
                    oRST_0  <= 1'b1;
                end
                ST_PU1: if (cnt_q == GAP_M) begin
                    state_q <= ST_PU2;
                    cnt_q   <= '0;
                    oRST_1  <= 1'b1;
                end
                ST_PU2: if (cnt_q == GAP_M) begin
                    state_q   <= ST_RUN;
                    cnt_q     <= '0;
                    oRST_2    <= 1'b1;
                    oMUTE_REQ <= 1'b0;
                    oBUSY     <= 1'b0;
                    oDONE     <= 1'b1;
                end
                ST_RUN: begin
                    cnt_q <= '0;
                    if (soft_req && !req_q) begin
                        state_q   <= ST_MUTE;
                        oMUTE_REQ <= 1'b1;
                        oBUSY     <= 1'b1;
                        oTMO      <= 1'b0;
                    end
                end
                ST_MUTE: if (mute_ack || cnt_q == TMO_M) begin
                    state_q <= ST_DN1;
                    cnt_q   <= '0;
                    oRST_2  <= 1'b0;
                    oTMO    <= !mute_ack;
                end
                ST_DN1: if (cnt_q == GAP_M) begin
                    state_q <= ST_DN0;
                    cnt_q   <= '0;
                    oRST_1  <= 1'b0;
                end
                ST_DN0: if (cnt_q == GAP_M) begin
                    state_q <= ST_HOLD;
                    cnt_q   <= '0;
                    oRST_0  <= 1'b0;
                end
                ST_HOLD: if (cnt_q == HOLD_M) begin
                    state_q <= ST_PU1;
                    cnt_q   <= '0;
                    oRST_0  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reset_shutdown_sequencer.sv
// tb_reset_shutdown_sequencer: directed vector bench for reset_shutdown_sequencer with GAP=4, HOLD=3, TIMEOUT=8
module tb_reset_shutdown_sequencer;
    typedef struct {
        int         n;
        logic       sreq;
        logic       ack;
        logic [6:0] exp;
        string      name;
    } vec_t;
    logic iCLK = 1'b0;
    logic reset_reg_N = 1'b1;
    logic soft_req = 1'b0;
    logic mute_ack = 1'b0;
    logic oRST_0, oRST_1, oRST_2, oMUTE_REQ, oBUSY, oDONE, oTMO;
    logic [6:0] outs;
    logic mon_en = 1'b0;
    int compared = 0;
    int mismatched = 0;
    vec_t v[$];

    reset_shutdown_sequencer #(.CNT_W(4), .GAP(4), .HOLD(3), .TIMEOUT(8)) dut (
        .iCLK(iCLK), .reset_reg_N(reset_reg_N), .soft_req(soft_req), .mute_ack(mute_ack),
        .oRST_0(oRST_0), .oRST_1(oRST_1), .oRST_2(oRST_2), .oMUTE_REQ(oMUTE_REQ),
        .oBUSY(oBUSY), .oDONE(oDONE), .oTMO(oTMO)
    );

    always #5 iCLK = ~iCLK;
    assign outs = {oRST_0, oRST_1, oRST_2, oMUTE_REQ, oBUSY, oDONE, oTMO};

    // Stage-ordering and done/busy exclusivity checked every cycle
    always @(negedge iCLK) if (mon_en) begin
        compared++;
        if (oRST_2 > oRST_1 || oRST_1 > oRST_0 || (oDONE && oBUSY)) begin
            mismatched++;
            $display("FAIL invariant @%0t: outs=%b", $time, outs);
        end
    end

    function automatic vec_t mk(input int n, input logic s, input logic a, input logic [6:0] e, input string nm);
        vec_t r;
        r.n = n; r.sreq = s; r.ack = a; r.exp = e; r.name = nm;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [6:0] exp);
        compared++;
        if (outs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b (rst0 rst1 rst2 mute busy done tmo)", nm, outs, exp);
        end
    endtask

    task automatic run_vec(input int i);
        soft_req = v[i].sreq;
        mute_ack = v[i].ack;
        repeat (v[i].n) @(negedge iCLK);
        chk(v[i].name, v[i].exp);
    endtask

    initial begin
        // outs order: rst0 rst1 rst2 mute busy done tmo; n = edges advanced before the check
        v.push_back(mk(3, 0, 0, 7'b0000100, "pu_e3"));
        v.push_back(mk(1, 0, 0, 7'b1000100, "pu_e4"));
        v.push_back(mk(3, 0, 0, 7'b1000100, "pu_e7"));
        v.push_back(mk(1, 0, 0, 7'b1100100, "pu_e8"));
        v.push_back(mk(3, 0, 0, 7'b1100100, "pu_e11"));
        v.push_back(mk(1, 0, 0, 7'b1110010, "pu_e12"));
        v.push_back(mk(1, 0, 0, 7'b1110000, "pu_e13"));
        v.push_back(mk(1, 1, 1, 7'b1111100, "ack_S"));
        v.push_back(mk(1, 1, 1, 7'b1101100, "ack_S1"));
        v.push_back(mk(3, 1, 1, 7'b1101100, "ack_S4"));
        v.push_back(mk(1, 1, 1, 7'b1001100, "ack_S5"));
        v.push_back(mk(3, 1, 1, 7'b1001100, "ack_S8"));
        v.push_back(mk(1, 1, 1, 7'b0001100, "ack_S9"));
        v.push_back(mk(2, 1, 1, 7'b0001100, "ack_S11"));
        v.push_back(mk(1, 1, 1, 7'b1001100, "ack_S12"));
        v.push_back(mk(3, 1, 1, 7'b1001100, "ack_S15"));
        v.push_back(mk(1, 1, 1, 7'b1101100, "ack_S16"));
        v.push_back(mk(3, 1, 1, 7'b1101100, "ack_S19"));
        v.push_back(mk(1, 1, 1, 7'b1110010, "ack_S20"));
        v.push_back(mk(1, 1, 1, 7'b1110000, "ack_S21"));
        v.push_back(mk(2, 0, 0, 7'b1110000, "idle"));
        v.push_back(mk(1, 1, 0, 7'b1111100, "tmo_S"));
        v.push_back(mk(7, 1, 0, 7'b1111100, "tmo_S7"));
        v.push_back(mk(1, 1, 0, 7'b1101101, "tmo_S8"));
        v.push_back(mk(1, 0, 0, 7'b1101101, "tmo_S9"));
        v.push_back(mk(1, 1, 0, 7'b1101101, "tmo_pulse"));
        v.push_back(mk(1, 0, 0, 7'b1101101, "tmo_S11"));
        v.push_back(mk(1, 0, 0, 7'b1001101, "tmo_S12"));
        v.push_back(mk(4, 0, 0, 7'b0001101, "tmo_S16"));
        v.push_back(mk(3, 0, 0, 7'b1001101, "tmo_S19"));
        v.push_back(mk(4, 0, 0, 7'b1101101, "tmo_S23"));
        v.push_back(mk(4, 0, 0, 7'b1110011, "tmo_S27"));
        v.push_back(mk(1, 0, 0, 7'b1110001, "tmo_S28"));
        v.push_back(mk(5, 0, 0, 7'b1110001, "no_second"));
        v.push_back(mk(1, 1, 1, 7'b1111100, "clr_S"));
        v.push_back(mk(1, 0, 1, 7'b1101100, "clr_S1"));
        v.push_back(mk(19, 0, 1, 7'b1110010, "clr_S20"));
        v.push_back(mk(1, 0, 1, 7'b1110000, "clr_S21"));

        #2 reset_reg_N = 1'b0;
        #1 chk("reset_values", 7'b0000100);
        mon_en = 1'b1;
        repeat (2) @(negedge iCLK);
        reset_reg_N = 1'b1;
        for (int i = 0; i < v.size(); i++) run_vec(i);

        // request level held high through reset and power-up must not restart
        @(negedge iCLK);
        reset_reg_N = 1'b0;
        soft_req = 1'b1;
        mute_ack = 1'b1;
        @(negedge iCLK);
        reset_reg_N = 1'b1;
        repeat (12) @(negedge iCLK);
        chk("held_pu_e12", 7'b1110010);
        repeat (10) @(negedge iCLK);
        chk("held_no_restart", 7'b1110000);

        // reset asserted mid-DN0 clears everything at once, then power-up reruns
        soft_req = 1'b0;
        @(negedge iCLK);
        soft_req = 1'b1;
        @(negedge iCLK);
        chk("dn0_S", 7'b1111100);
        repeat (7) @(negedge iCLK);
        chk("dn0_S7", 7'b1001100);
        #2 reset_reg_N = 1'b0;
        #1 chk("dn0_async_reset", 7'b0000100);
        @(negedge iCLK);
        reset_reg_N = 1'b1;
        for (int i = 0; i < 7; i++) run_vec(i);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
